// File: rtl/hdb3_pkg.sv
// hdb3_pkg: symbol alphabet and pipeline depth shared by the HDB3 encoder blocks
package hdb3_pkg;
    typedef logic [1:0] sym_t;
    localparam sym_t SYM_ZERO = 2'b00;
    localparam sym_t SYM_ONE  = 2'b01;
    localparam sym_t SYM_B    = 2'b10;
    localparam sym_t SYM_V    = 2'b11;
    localparam int PIPE_DEPTH = 4;
endpackage

// File: rtl/hdb3_polarity.sv
// hdb3_polarity: maps the outgoing symbol to bp/bn rails, tracking last pulse polarity
module hdb3_polarity
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  sym_t sym,
    output logic bp,
    output logic bn
);
    logic last_pos;
    logic pos;
    logic mark;
    // a violation repeats the last polarity, every other mark alternates
    always_comb begin
        mark = sym != SYM_ZERO;
        pos  = (sym == SYM_V) ? last_pos : ~last_pos;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bp       <= 1'b0;
            bn       <= 1'b0;
            last_pos <= 1'b0;
        end else begin
            bp       <= mark & pos;
            bn       <= mark & ~pos;
            last_pos <= mark ? pos : last_pos;
        end
    end
endmodule

// File: rtl/hdb3_encoder.sv
// hdb3_encoder: NRZ to HDB3 line encoder; classifies bits, substitutes B00V/000V,
// delays four symbols so a balancing pulse can be placed on the first zero of a run
module hdb3_encoder
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic bp,
    output logic bn
);
    sym_t       pipe [PIPE_DEPTH];
    sym_t       sym;
    logic [1:0] zcnt;
    logic       parity;
    logic       is_v;
    logic       insert_b;
    always_comb begin
        is_v     = !data_in && zcnt == 2'd3;
        sym      = data_in ? SYM_ONE : (is_v ? SYM_V : SYM_ZERO);
        insert_b = is_v && !parity;
    end
    // the first zero of the run shifts into the last stage on the same edge the V is classified
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zcnt   <= 2'd0;
            parity <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= SYM_ZERO;
        end else begin
            pipe[0] <= sym;
            for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
            if (insert_b) pipe[PIPE_DEPTH-1] <= SYM_B;
            zcnt   <= (data_in || is_v) ? 2'd0 : zcnt + 2'd1;
            parity <= is_v ? 1'b0 : (data_in ? ~parity : parity);
        end
    end
    hdb3_polarity u_pol (
        .clk   (clk),
        .rst_n (rst_n),
        .sym   (pipe[PIPE_DEPTH-1]),
        .bp    (bp),
        .bn    (bn)
    );
endmodule

// File: tb/tb_hdb3_encoder.sv
// tb_hdb3_encoder: directed HDB3 vectors checked through a scoreboard queue plus line invariants
module tb_hdb3_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data_in = 1'b0;
    logic bp, bn;
    byte  expq [$];
    int   checks = 0;
    int   errors = 0;
    int   since, zrun, sum;
    logic last_pos, last_v, have_v;
    logic [1:0] want;
    byte  e;

    hdb3_encoder dut (.clk(clk), .rst_n(rst_n), .data_in(data_in), .bp(bp), .bn(bn));

    always #5 clk = ~clk;

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            data_in = 1'b1;
            expq.push_back("0");
        end
    endtask

    task automatic run(input string d, input string x);
        for (int i = 0; i < d.len(); i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            data_in = (d[i] == "1");
            if (i < x.len()) expq.push_back(x[i]);
        end
    endtask

    task automatic runs(input int n, input int len);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                rst_n = 1'b1;
                data_in = i[0] ? 1'b0 : 1'b1;
            end
    endtask

    always @(posedge clk) begin
        #2;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            want = (e == "+") ? 2'b10 : (e == "-") ? 2'b01 : 2'b00;
            checks++;
            if ({bp, bn} !== want) begin
                errors++;
                $display("FAIL sym: got bp/bn=%b%b want %b at %0t", bp, bn, want, $time);
            end
        end
        checks++;
        if (bp === 1'b1 && bn === 1'b1) begin
            errors++;
            $display("FAIL both_rails: got bp=1 bn=1 want not both at %0t", $time);
        end
        if (!rst_n) begin
            since = 0; zrun = 0; sum = 0;
            last_pos = 1'b0; last_v = 1'b0; have_v = 1'b0;
        end else begin
            since++;
            if (since >= 5) begin
                zrun = (bp || bn) ? 0 : zrun + 1;
                checks++;
                if (zrun > 3) begin
                    errors++;
                    $display("FAIL zero_run: got %0d zeros want <=3 at %0t", zrun, $time);
                end
            end
            if (bp ^ bn) begin
                if (bp == last_pos) begin
                    if (have_v) begin
                        checks++;
                        if (last_v == bp) begin
                            errors++;
                            $display("FAIL v_alt: got V polarity %b twice want alternate at %0t", bp, $time);
                        end
                    end
                    have_v = 1'b1;
                    last_v = bp;
                end
                last_pos = bp;
                sum += bp ? 1 : -1;
                checks++;
                if (sum > 2 || sum < -2) begin
                    errors++;
                    $display("FAIL dc_sum: got %0d want within +-2 at %0t", sum, $time);
                end
            end
        end
    end

    initial begin
        rst_cycles(2);
        run("11000010000", "0000+-+00+-");
        rst_cycles(2);
        run("1000010000", "0000+000+-");
        rst_cycles(2);
        run("0000000010000", "0000+00+-00-+");
        run("1101", "");
        rst_cycles(3);
        run("110000", "0000+-");
        rst_cycles(2);
        run("0000", "0000");
        runs(12, 25);
        runs(6, 7);
        runs(8, 3);
        rst_cycles(1);
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hdb3_encoder.md
Name: hdb3_encoder

Overview:
Line encoder that converts a serial NRZ bit stream into HDB3 (High-Density Bipolar 3) ternary symbols, presented on two unipolar rails, bp (positive pulse) and bn (negative pulse). It sits between the serial data source and the line driver or transformer stage. Every rising clock edge consumes one input bit and emits one output symbol, after a fixed pipeline delay.

Parameters:
none (one bit per clock; any bit-rate division is done upstream)

Ports:
clk      input   1  system clock, rising-edge active; one bit and one symbol per cycle
rst_n    input   1  reset, synchronous, active-low
data_in  input   1  NRZ data bit, sampled on every rising edge of clk
bp       output  1  1 = positive mark on line in this cycle
bn       output  1  1 = negative mark on line in this cycle

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state and outputs are registered on the clk rising edge.
- Reset (rst_n=0 at an edge):
  - bp=0, bn=0.
  - Pipeline filled with zero symbols; zero-run count=0; pulse-parity=even.
  - Last-pulse polarity=negative, so the first pulse after reset is positive.
  - Reset mid-stream discards all in-flight bits.
- Internal symbol alphabet (2 bits): ZERO, ONE, B (balancing pulse), V (violation).
- Stage 1, classification, at each edge:
  - data_in=1 -> ONE; zero-run count cleared.
  - data_in=0 -> zero-run count+1. If this is the 4th consecutive zero -> V, and the count clears. Otherwise -> ZERO.
  - Zero runs are counted only from bits sampled after reset.
- B substitution:
  - When a V is generated and pulse-parity is even, the oldest stage of the 4-deep delay line is loaded with B instead of ZERO. This is the first zero of the run, bit k-3.
  - Result: even parity -> B00V; odd parity -> 000V.
- Pulse-parity:
  - Toggles on each ONE and each inserted B.
  - Clears to even on each V.
- Delay line: 4 symbol stages (reg0..reg3); a new symbol enters reg0 and shifts toward reg3.
- Stage 2, polarity, on the symbol leaving reg3:
  - ZERO -> bp=0, bn=0.
  - ONE or B -> a pulse opposite to the last pulse; update last-pulse polarity.
  - V -> a pulse of the same polarity as the last pulse; last-pulse polarity is unchanged.
- Latency: the bit sampled at edge k is driven on bp/bn from edge k+4. For the first 4 edges after reset release, outputs are 0.
- Invariants:
  - bp and bn are never both 1.
  - No more than 3 consecutive zero symbols after the pipeline fills.
  - Successive V pulses alternate polarity.
  - Running DC sum stays within ±2.

Decomposition:
- Package hdb3_pkg: 2-bit symbol typedef plus constants SYM_ZERO=00, SYM_ONE=01, SYM_B=10, SYM_V=11; constant PIPE_DEPTH=4.
- One natural sub-module, hdb3_polarity: takes the reg3 symbol and produces registered bp/bn while holding the last-polarity flag.
- The top module holds the classifier, zero/parity counters and delay line.

Test Plan:
- Reset, then data 1,1,0,0,0,0,1 (one bit per clock). Required bp/bn sequence from edge 4 after release: +,-,+(B),0,0,+(V),-.
- Reset, then data 1,0,0,0,0,1. Required: +,0,0,0,+(V),- (odd parity -> 000V).
- Reset, then 8 zeros followed by 1. Required: +(B),0,0,+(V),-(B),0,0,-(V),+.
- Hold rst_n=0 for 3 cycles mid-stream, then feed 1,1. Required: bp=bn=0 during reset and for 4 edges after release, then +,-.
- Long stimulus with data held at each level for 25 clocks (runs of 1s and 0s as in system use). Check on every cycle: bp&bn never 1, no 4 consecutive zero symbols, V polarities alternate, and the running sum stays within ±2.
